uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART TX register write port between two byte requesters: requester 0 is the core's store path and requester 1 is the student-ID sequencer. The block paces writes so that each byte gets one full serial frame time before the next write. It issues a one-cycle write strobe toward rib, instead of letting a requester hold write-enable for the whole frame. Optionally, it lets a requester lock the port so that a multi-byte string is never interleaved.

## Interface
Parameters:
- BAUD_DIV, 32'h1B8, UART divider in clk cycles per bit (115200 bps).
- FRAME_BITS, 10, bits per serial frame (start + 8 data + stop).
- Derived: FRAME_CYCLES = BAUD_DIV*FRAME_BITS, computed in 32 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req0_valid_i  in  1  requester 0 has a byte.
- req0_data_i  in  8  requester 0 byte.
- req0_lock_i  in  1  requester 0 requests a port lock.
- req0_ready_o  out  1  requester 0 byte accepted this cycle.
- req1_valid_i / req1_data_i / req1_lock_i / req1_ready_o: same as requester 0, for requester 1.
- mem_waddr_o  out  32  constant `UART_TX_ADDR.
- mem_wdata_o  out  32  {24'h0, byte}.
- mem_we_o  out  1  one-cycle write strobe to rib.
- busy_o  out  1  frame in progress (state != IDLE).
- owner_o  out  1  index of the requester whose byte was last accepted.

## Operation
- States: IDLE, WRITE, WAIT.
- **IDLE:** computes grant and asserts the ready of the granted requester only. A transfer happens when valid and ready are both high in the same cycle.
  - On a transfer: latch the byte, set owner_o, set last_grant, go to WRITE.
- **WRITE:** mem_we_o=1 for exactly one cycle; mem_wdata_o holds the byte; load the pacing counter with 1; go to WAIT.
- **WAIT:** increment the counter. When the counter equals FRAME_CYCLES-1, go to IDLE. The ready outputs are 0 throughout.
- **Grant rule in IDLE (no lock active):**
  - Exactly one valid: that requester wins.
  - Both valid: the requester that is not last_grant wins (round-robin).
  - None valid: no ready.
- ready_o depends combinationally on the valid inputs and the state. Requesters must hold valid and data stable until ready is seen.
- mem_wdata_o and owner_o hold their values after WRITE until the next transfer.
- mem_we_o is 0 in IDLE and WAIT.
- Requester data never reaches mem_wdata_o without a handshake.

## Timing
- Reset values: state IDLE, mem_we_o 0, mem_wdata_o 0, busy_o 0, owner_o 0, last_grant 1 (requester 0 wins the first tie), lock inactive, counter 0. mem_waddr_o is always `UART_TX_ADDR.
- Handshake in cycle N:
  - mem_we_o is high in cycle N+1.
  - busy_o is high from N+1 through N+FRAME_CYCLES.
  - IDLE is reached in cycle N+FRAME_CYCLES+1, which is the earliest next handshake.
  - Minimum spacing between mem_we_o pulses is FRAME_CYCLES+1 cycles.
- A valid asserted during WRITE or WAIT waits; it is not lost.
- Reset mid-frame aborts the frame. The block is in IDLE the following cycle with all reset values. A byte whose strobe was already issued is not replayed.
- FRAME_CYCLES<2 is not supported.

## Configuration
- Macro: UART_ARB_LOCK_EN.
- **Defined:**
  - Accepting a byte while that requester's lock_i=1 sets the lock to that requester.
  - While the lock is set, in IDLE only the owner can be granted, even if the other requester is valid.
  - The lock clears in any IDLE cycle where the owner's lock_i=0. Grant that cycle follows the normal round-robin rule.
  - Reset clears the lock.
- **Undefined:** lock_i inputs are ignored and grant is pure per-byte round-robin.

## Test plan
All scenarios use BAUD_DIV=4, FRAME_BITS=10, so FRAME_CYCLES=40.
- Single byte: req0 sends 0x32 at cycle N -> mem_we_o=1 only at N+1, mem_wdata_o=32'h00000032, busy_o high N+1..N+40, req0_ready_o next high at N+41 if still valid.
- Tie after reset: both valid (req0 0x41, req1 0x42) -> 0x41 written first, then 0x42 41 cycles later, then alternating while both stay valid; owner_o toggles 0,1,0.
- Lock (macro defined): req1 streams 10 bytes with lock_i=1 ("2023310655" ASCII) while req0 is continuously valid -> all 10 req1 bytes written contiguously, 41 cycles apart; req0 served only after req1 drops lock_i.
- Lock (macro undefined): same stimulus -> req0 and req1 bytes interleave one-for-one.
- Reset mid-frame: rst at N+10 of a frame -> next cycle busy_o=0, mem_we_o=0, state IDLE; a held req1 valid is accepted in the first post-reset cycle.
- Hold check: req0 changes data while not ready during WAIT -> only the data present at the handshake cycle appears on mem_wdata_o.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter for the UART TX register: one-cycle write strobe, frame-time pacing.
// Optional port lock for multi-byte strings is enabled by defining UART_ARB_LOCK_EN.
`ifndef UART_TX_ADDR
`define UART_TX_ADDR 32'h1000_0000
`endif

module uart_tx_arbiter #(
  parameter logic [31:0] BAUD_DIV   = 32'h1B8,
  parameter logic [31:0] FRAME_BITS = 32'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid_i,
  input  logic [7:0]  req0_data_i,
  input  logic        req0_lock_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [7:0]  req1_data_i,
  input  logic        req1_lock_i,
  output logic        req1_ready_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        busy_o,
  output logic        owner_o
);

  localparam logic [31:0] FRAME_CYCLES = BAUD_DIV * FRAME_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT
  } state_t;

  state_t      state;
  logic [31:0] counter;
  logic        last_grant;
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic        lock_hold;

  assign mem_waddr_o  = `UART_TX_ADDR;
  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign xfer         = grant0 | grant1;

`ifdef UART_ARB_LOCK_EN
  logic lock_active;
  logic owner_lock;

  // While locked the lock owner is always the requester of the last accepted byte.
  assign owner_lock = owner_o ? req1_lock_i : req0_lock_i;
  assign lock_hold  = lock_active & owner_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
    end else if (state == IDLE) begin
      if (xfer) begin
        lock_active <= grant1 ? req1_lock_i : req0_lock_i;
      end else if (lock_active && !owner_lock) begin
        lock_active <= 1'b0;
      end
    end
  end
`else
  logic unused_lock;

  assign unused_lock = req0_lock_i ^ req1_lock_i;
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (lock_hold) begin
        grant0 = !owner_o && req0_valid_i;
        grant1 =  owner_o && req1_valid_i;
      end else if (req0_valid_i && req1_valid_i) begin
        grant0 =  last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      last_grant  <= 1'b1;
      owner_o     <= 1'b0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            mem_wdata_o <= {24'h0, (grant1 ? req1_data_i : req0_data_i)};
            owner_o     <= grant1;
            last_grant  <= grant1;
            mem_we_o    <= 1'b1;
            busy_o      <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          counter <= 32'd1;
          state   <= WAIT;
        end
        WAIT: begin
          counter <= counter + 32'd1;
          if (counter == FRAME_CYCLES - 32'd1) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
